// File: rtl/sram_512x28_adapter_if.sv
// Request/grant/response memory port between a requester and the 512x28 SRAM adapter.
interface sram_512x28_adapter_if;
   logic        req;
   logic        we;
   logic [8:0]  addr;
   logic [27:0] wdata;
   logic [27:0] wmask;
   logic        gnt;
   logic        rvalid;
   logic [27:0] rdata;
   logic        init_done;

   modport master (output req, we, addr, wdata, wmask,
                   input  gnt, rvalid, rdata, init_done);
   modport slave  (input  req, we, addr, wdata, wmask,
                   output gnt, rvalid, rdata, init_done);
endinterface

// File: rtl/sram_512x28_adapter.sv
// Adapter from a req/gnt/rvalid port to the 512x28 bit-enable SRAM macro strobes.
// Optional post-reset clearing sweep is enabled by defining SRAM_ADAPTER_INIT_EN.
module sram_512x28_adapter #(
   parameter logic [2:0]  MC_VAL     = 3'b000,
   parameter logic        MCEN_VAL   = 1'b0,
   parameter logic [1:0]  WA_VAL     = 2'b00,
   parameter logic [1:0]  WPULSE_VAL = 2'b00,
   parameter logic [27:0] INIT_VAL   = 28'h0
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   sram_512x28_adapter_if.slave  bus,
   output logic                  sram_ren_o,
   output logic                  sram_wen_o,
   output logic [8:0]            sram_adr_o,
   output logic [27:0]           sram_din_o,
   output logic [27:0]           sram_wbeb_o,
   output logic [2:0]            sram_mc_o,
   output logic                  sram_mcen_o,
   output logic [1:0]            sram_wa_o,
   output logic [1:0]            sram_wpulse_o,
   output logic                  sram_wpulseen_o,
   output logic                  sram_clkbyp_o,
   output logic                  sram_fwen_o,
   input  logic [27:0]           sram_q_i
);

   localparam logic [0:0] ST_INIT  = 1'b0;
   localparam logic [0:0] ST_READY = 1'b1;

   logic [0:0] state_q, state_d;
   logic       rvalid_q, rvalid_d;
   logic       rd_q, rd_d;

`ifdef SRAM_ADAPTER_INIT_EN
   logic [8:0] cnt_q, cnt_d;
   logic       run_q, run_d;
`else
   logic       unused_init_val;
   assign unused_init_val = ^INIT_VAL;
`endif

   always_comb begin
      state_d     = state_q;
      bus.gnt     = 1'b0;
      sram_ren_o  = 1'b0;
      sram_wen_o  = 1'b0;
      sram_adr_o  = '0;
      sram_din_o  = '0;
      sram_wbeb_o = '1;
`ifdef SRAM_ADAPTER_INIT_EN
      cnt_d       = cnt_q;
      run_d       = 1'b1;
`endif
      case (state_q)
         ST_INIT: begin
`ifdef SRAM_ADAPTER_INIT_EN
            // run_q holds the sweep off for one cycle so the pins stay quiet
            // while reset is asserted and the first write lands on edge 2.
            if (run_q) begin
               sram_wen_o  = 1'b1;
               sram_adr_o  = cnt_q;
               sram_din_o  = INIT_VAL;
               sram_wbeb_o = '0;
               cnt_d       = cnt_q + 9'd1;
               if (cnt_q == 9'h1FF) state_d = ST_READY;
            end
`else
            state_d = ST_READY;
`endif
         end
         default: begin
            bus.gnt = bus.req;
            if (bus.req) begin
               sram_ren_o  = ~bus.we;
               sram_wen_o  = bus.we;
               sram_adr_o  = bus.addr;
               sram_din_o  = bus.wdata;
               sram_wbeb_o = bus.we ? ~bus.wmask : '1;
            end
         end
      endcase
      rvalid_d = bus.gnt;
      rd_d     = bus.gnt & ~bus.we;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_INIT;
         rvalid_q <= 1'b0;
         rd_q     <= 1'b0;
`ifdef SRAM_ADAPTER_INIT_EN
         cnt_q    <= '0;
         run_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         rvalid_q <= rvalid_d;
         rd_q     <= rd_d;
`ifdef SRAM_ADAPTER_INIT_EN
         cnt_q    <= cnt_d;
         run_q    <= run_d;
`endif
      end
   end

   assign bus.rvalid    = rvalid_q;
   assign bus.rdata     = (rvalid_q && rd_q) ? sram_q_i : '0;
   assign bus.init_done = (state_q == ST_READY);

   assign sram_mc_o       = MC_VAL;
   assign sram_mcen_o     = MCEN_VAL;
   assign sram_wa_o       = WA_VAL;
   assign sram_wpulse_o   = WPULSE_VAL;
   assign sram_wpulseen_o = |WPULSE_VAL;
   assign sram_clkbyp_o   = 1'b0;
   assign sram_fwen_o     = 1'b0;

endmodule

// File: tb/tb_sram_512x28_adapter.sv
// Self-checking bench for sram_512x28_adapter with a behavioural macro and reference memory.
module tb_sram_512x28_adapter;
   localparam logic [27:0] INIT_VAL = 28'h5A5_A5A5;
`ifdef SRAM_ADAPTER_INIT_EN
   localparam bit INIT_EN = 1'b1;
`else
   localparam bit INIT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sram_512x28_adapter_if bus();

   logic        ren, wen, wpulseen, mcen, clkbyp, fwen;
   logic [8:0]  adr;
   logic [27:0] din, wbeb, q;
   logic [2:0]  mc;
   logic [1:0]  wa, wpulse;

   sram_512x28_adapter #(
      .MC_VAL(3'b101), .MCEN_VAL(1'b0), .WA_VAL(2'b00),
      .WPULSE_VAL(2'b10), .INIT_VAL(INIT_VAL)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus),
      .sram_ren_o(ren), .sram_wen_o(wen), .sram_adr_o(adr), .sram_din_o(din),
      .sram_wbeb_o(wbeb), .sram_mc_o(mc), .sram_mcen_o(mcen), .sram_wa_o(wa),
      .sram_wpulse_o(wpulse), .sram_wpulseen_o(wpulseen), .sram_clkbyp_o(clkbyp),
      .sram_fwen_o(fwen), .sram_q_i(q)
   );

   // behavioural macro: active-low bit enables, registered read port
   logic [27:0] macro_mem [512];
   always @(posedge clk) begin
      if (wen) macro_mem[adr] <= (macro_mem[adr] & wbeb) | (din & ~wbeb);
      if (ren) q <= macro_mem[adr];
   end

   int          checks = 0;
   int          errors = 0;
   logic [27:0] ref_mem [512];
   bit          known [512];
   logic        exp_rv = 1'b0;
   logic [27:0] exp_rd = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_static();
      check("mc", {29'd0, mc}, 32'd5);
      check("wpulseen", {31'd0, wpulseen}, 32'd1);
      check("clkbyp", {31'd0, clkbyp}, 32'd0);
   endtask

   task automatic check_reset_pins();
      check("rst_gnt", {31'd0, bus.gnt}, 32'd0);
      check("rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
      check("rst_rdata", {4'd0, bus.rdata}, 32'd0);
      check("rst_ren", {31'd0, ren}, 32'd0);
      check("rst_wen", {31'd0, wen}, 32'd0);
      check("rst_adr", {23'd0, adr}, 32'd0);
      check("rst_din", {4'd0, din}, 32'd0);
      check("rst_wbeb", {4'd0, wbeb}, {4'd0, 28'hFFF_FFFF});
      check("rst_init_done", {31'd0, bus.init_done}, 32'd0);
      check_static();
   endtask

   // one bus cycle; entered and left at posedge+1
   task automatic step(input logic r, input logic w, input logic [8:0] a,
                       input logic [27:0] d, input logic [27:0] m);
      bus.req = r; bus.we = w; bus.addr = a; bus.wdata = d; bus.wmask = m;
      #3;
      check("gnt", {31'd0, bus.gnt}, {31'd0, r});
      check("ren", {31'd0, ren}, {31'd0, r & ~w});
      check("wen", {31'd0, wen}, {31'd0, r & w});
      check("wbeb", {4'd0, wbeb}, {4'd0, (r && w) ? ~m : 28'hFFF_FFFF});
      check("not_both", {31'd0, ren & wen}, 32'd0);
      if (r) begin
         check("adr", {23'd0, adr}, {23'd0, a});
         if (w) check("din", {4'd0, din}, {4'd0, d});
      end
      check("rvalid", {31'd0, bus.rvalid}, {31'd0, exp_rv});
      check("rdata", {4'd0, bus.rdata}, {4'd0, exp_rd});
      exp_rv = r;
      exp_rd = (r && !w) ? ref_mem[a] : 28'h0;
      if (r && w) begin
         ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
         known[a] = 1'b1;
      end
      @(posedge clk); #1;
   endtask

   // holds req high until init_done, checking no grant and the sweep start
   task automatic wait_ready(input int exp_n);
      int n;
      bus.req = 1'b1; bus.we = 1'b0; bus.addr = 9'h0AA; bus.wdata = '0; bus.wmask = '0;
      n = 0;
      for (int i = 1; i <= 700; i++) begin
         @(posedge clk); #1;
         n = i;
         if (INIT_EN && i == 1) begin
            check("sweep_adr0", {23'd0, adr}, 32'd0);
            check("sweep_wen", {31'd0, wen}, 32'd1);
            check("sweep_wbeb", {4'd0, wbeb}, 32'd0);
            check("sweep_din", {4'd0, din}, {4'd0, INIT_VAL});
         end
         if (bus.init_done) break;
         if (bus.gnt !== 1'b0 || bus.rvalid !== 1'b0) check("init_no_gnt", {30'd0, bus.gnt, bus.rvalid}, 32'd0);
      end
      check("init_cycles", n, exp_n);
      bus.req = 1'b0;
      exp_rv = 1'b0; exp_rd = '0;
      if (INIT_EN) for (int k = 0; k < 512; k++) begin ref_mem[k] = INIT_VAL; known[k] = 1'b1; end
   endtask

   initial begin
      int exp_n;
      logic [8:0]  a;
      logic [27:0] d, m;
      logic        r, w;
      exp_n = INIT_EN ? 513 : 1;
      for (int k = 0; k < 512; k++) begin ref_mem[k] = 'x; known[k] = 1'b0; end
      bus.req = 1'b1; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.wmask = '0;
      #12;
      check_reset_pins();
      rst_n = 1'b1;
      wait_ready(exp_n);
      @(posedge clk); #1;

      if (INIT_EN) begin
         step(1, 0, 9'h000, 0, 0);
         step(1, 0, 9'h1FF, 0, 0);
         step(0, 0, 0, 0, 0);
      end

      // single write then read-back
      step(1, 1, 9'h005, 28'hABC_DEF1, 28'hFFF_FFFF);
      step(1, 0, 9'h005, 0, 0);
      step(0, 0, 0, 0, 0);

      // masked partial write
      step(1, 1, 9'h1FF, 28'hFFF_FFFF, 28'hFFF_FFFF);
      step(1, 1, 9'h1FF, 28'h000_0000, 28'h000_00FF);
      step(1, 0, 9'h1FF, 0, 0);
      step(0, 0, 0, 0, 0);
      check("masked_value", {4'd0, ref_mem[9'h1FF]}, {4'd0, 28'hFFF_FF00});

      // fill then stream 16 back-to-back reads
      for (int k = 0; k < 16; k++) step(1, 1, 9'(k), 28'($urandom), 28'hFFF_FFFF);
      for (int k = 0; k < 16; k++) step(1, 0, 9'(k), 0, 0);
      step(0, 0, 0, 0, 0);

      // randomized traffic, biased to a small window for read-after-write hits
      for (int k = 0; k < 300; k++) begin
         r = ($urandom_range(0, 3) != 0);
         w = $urandom_range(0, 1);
         a = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 15));
         d = 28'($urandom);
         m = ($urandom_range(0, 7) == 0) ? 28'h0 : 28'($urandom);
         if (r && !w && !known[a]) begin w = 1'b1; m = 28'hFFF_FFFF; end
         step(r, w, a, d, m);
      end
      step(0, 0, 0, 0, 0);

      // asynchronous reset in the cycle after a read grant
      step(1, 0, 9'h005, 0, 0);
      rst_n = 1'b0;
      #1;
      check_reset_pins();
      #2 rst_n = 1'b1;
      wait_ready(exp_n);
      @(posedge clk); #1;
      step(1, 0, 9'h005, 0, 0);
      step(1, 0, 9'h003, 0, 0);
      step(0, 0, 0, 0, 0);
      check_static();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
